// File: rtl/npu_pe_pkg.sv
// Shared widths, result quantisation and the accumulator-width guard for the
// conv-array processing element.
package npu_pe_pkg;

  localparam int DEF_CELL_W = 8;
  localparam int DEF_N_CELL = 9;

  // Width of one signed CELL_W x CELL_W product.
  function automatic int calc_prod_w(input int cell_w);
    return 2 * cell_w;
  endfunction

  // Width of one beat's dot product. The extra guard bit also leaves room for
  // the bias added on a group's first beat.
  function automatic int calc_sum_w(input int cell_w, input int n_cell);
    return 2 * cell_w + $clog2(n_cell) + 1;
  endfunction

  localparam int PROD_W = calc_prod_w(DEF_CELL_W);
  localparam int SUM_W  = calc_sum_w(DEF_CELL_W, DEF_N_CELL);

  // Floor arithmetic right shift, saturation to a signed out_w range, then an
  // optional ReLU clamp. A shift past the top of the accumulator behaves as a
  // full sign-fill shift.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input logic [31:0]        shift,
    input logic               relu,
    input int                 acc_w,
    input int                 out_w
  );
    logic [31:0]        sh;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = (shift > 32'(acc_w - 1)) ? 32'(acc_w - 1) : shift;
    r  = acc >>> sh;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    if (relu && (r < 64'sd0)) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// A full group of 2^step_w beat sums must fit the accumulator without wrap.
`define NPU_PE_ACC_W_CHECK(ACC_W_, MIN_W_) \
  if ((ACC_W_) < (MIN_W_)) begin : g_acc_w_check \
    $error("pe_mac_acc: ACC_W is too narrow for a full group of beat sums"); \
  end

// File: rtl/pe_dot_stage.sv
// Stage 1 of the PE: N_CELL signed multipliers, a balanced adder tree, the
// first-beat bias add and the stage-1 register with its beat flags.
module pe_dot_stage
  import npu_pe_pkg::*;
#(
  parameter int CELL_W = 8,
  parameter int N_CELL = 9,
  parameter int BIAS_W = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          en,
  input  logic [CELL_W*N_CELL-1:0]                      in_data,
  input  logic [CELL_W*N_CELL-1:0]                      weight,
  input  logic signed [BIAS_W-1:0]                      bias,
  input  logic                                          first,
  input  logic                                          last,
  output logic signed [calc_sum_w(CELL_W, N_CELL)-1:0]  s1,
  output logic                                          s1_valid,
  output logic                                          s1_first,
  output logic                                          s1_last
);

  localparam int PW = calc_prod_w(CELL_W);
  localparam int SW = calc_sum_w(CELL_W, N_CELL);
  localparam int NP = 1 << $clog2(N_CELL);

  logic signed [SW-1:0] s1_d, s1_q;
  logic                 s1_valid_d, s1_valid_q;
  logic                 s1_first_d, s1_first_q;
  logic                 s1_last_d, s1_last_q;
  logic signed [SW-1:0] tree [NP];
  logic signed [SW-1:0] bias_ext;

  // Products into a power-of-two leaf array, pairwise reduction, bias on first beat.
  always_comb begin
    logic signed [CELL_W-1:0] a;
    logic signed [CELL_W-1:0] b;
    logic signed [PW-1:0]     p;
    for (int k = 0; k < NP; k++) begin
      tree[k] = '0;
    end
    for (int k = 0; k < N_CELL; k++) begin
      a       = in_data[k*CELL_W +: CELL_W];
      b       = weight[k*CELL_W +: CELL_W];
      p       = a * b;
      tree[k] = SW'(p);
    end
    for (int w = NP / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        tree[i] = tree[2*i] + tree[2*i+1];
      end
    end
    bias_ext   = first ? SW'(bias) : '0;
    s1_d       = s1_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_valid_d = en;
    if (en) begin
      s1_d       = tree[0] + bias_ext;
      s1_first_d = first;
      s1_last_d  = last;
    end
  end

  // Stage-1 register; data and flags hold between beats, valid pulses per beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
    end
  end

  assign s1       = s1_q;
  assign s1_valid = s1_valid_q;
  assign s1_first = s1_first_q;
  assign s1_last  = s1_last_q;

endmodule

// File: rtl/pe_mac_acc.sv
// Processing element: signed dot product plus bias, accumulated over step+1
// beats, then shifted, saturated and optionally ReLU-clamped.
//
// Handshake: there is no back-pressure. A beat is accepted at every rising
// edge where en=1; out_valid is a single-cycle pulse one edge after a group's
// last beat is accepted, and out holds that result until the next one.
// clear at an edge discards every beat accepted before that edge.
module pe_mac_acc
  import npu_pe_pkg::*;
#(
  parameter int CELL_W  = 8,
  parameter int N_CELL  = 9,
  parameter int BIAS_W  = 16,
  parameter int OUT_W   = 8,
  parameter int STEP_W  = 3,
  parameter int SHIFT_W = 5,
  parameter int ACC_W   = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [CELL_W*N_CELL-1:0]   in_data,
  input  logic [CELL_W*N_CELL-1:0]   weight,
  input  logic signed [BIAS_W-1:0]   bias,
  input  logic [STEP_W-1:0]          step,
  input  logic [SHIFT_W-1:0]         shift,
  input  logic                       relu,
  input  logic                       clear,
  output logic signed [OUT_W-1:0]    out,
  output logic                       out_valid,
  output logic                       busy
);

  localparam int SW = calc_sum_w(CELL_W, N_CELL);

  `NPU_PE_ACC_W_CHECK(ACC_W, SW + STEP_W)

  logic                     grp_open_d, grp_open_q;
  logic [STEP_W-1:0]        cnt_d, cnt_q;
  logic [STEP_W-1:0]        step_d, step_q;
  logic [SHIFT_W-1:0]       grp_shift_d, grp_shift_q;
  logic                     grp_relu_d, grp_relu_q;
  logic [SHIFT_W-1:0]       s1_shift_d, s1_shift_q;
  logic                     s1_relu_d, s1_relu_q;
  logic signed [ACC_W-1:0]  acc_d, acc_q;
  logic signed [OUT_W-1:0]  out_d, out_q;
  logic                     out_valid_d, out_valid_q;

  logic                     beat_first;
  logic                     beat_last;
  logic [STEP_W-1:0]        beat_idx;
  logic [STEP_W-1:0]        eff_step;

  logic signed [SW-1:0]     s1;
  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_last;

  logic signed [ACC_W-1:0]  s1_ext;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [OUT_W-1:0]  res;

  pe_dot_stage #(
    .CELL_W (CELL_W),
    .N_CELL (N_CELL),
    .BIAS_W (BIAS_W)
  ) u_dot (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_data  (in_data),
    .weight   (weight),
    .bias     (bias),
    .first    (beat_first),
    .last     (beat_last),
    .s1       (s1),
    .s1_valid (s1_valid),
    .s1_first (s1_first),
    .s1_last  (s1_last)
  );

  // Beat counter and per-group parameter latches; clear reopens at beat 0.
  always_comb begin
    beat_first  = clear | ~grp_open_q;
    eff_step    = beat_first ? step : step_q;
    beat_idx    = beat_first ? '0 : cnt_q;
    beat_last   = (beat_idx == eff_step);
    grp_open_d  = grp_open_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    grp_shift_d = grp_shift_q;
    grp_relu_d  = grp_relu_q;
    s1_shift_d  = s1_shift_q;
    s1_relu_d   = s1_relu_q;
    if (clear) begin
      grp_open_d = 1'b0;
      cnt_d      = '0;
    end
    if (en) begin
      if (beat_first) begin
        step_d      = step;
        grp_shift_d = shift;
        grp_relu_d  = relu;
      end
      // Travel with the beat so a back-to-back group cannot disturb this result.
      s1_shift_d = beat_first ? shift : grp_shift_q;
      s1_relu_d  = beat_first ? relu : grp_relu_q;
      grp_open_d = ~beat_last;
      cnt_d      = beat_last ? '0 : beat_idx + 1'b1;
    end
  end

  // Stage 2: accumulate the beat sum and quantise on the group's last beat.
  always_comb begin
    s1_ext      = ACC_W'(s1);
    acc_base    = s1_first ? '0 : acc_q;
    acc_sum     = acc_base + s1_ext;
    res         = OUT_W'(sat_shift(64'(acc_sum), 32'(s1_shift_q), s1_relu_q, ACC_W, OUT_W));
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (s1_valid) begin
      if (s1_last) begin
        acc_d       = '0;
        out_d       = res;
        out_valid_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Group state, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grp_open_q  <= 1'b0;
      cnt_q       <= '0;
      step_q      <= '0;
      grp_shift_q <= '0;
      grp_relu_q  <= 1'b0;
      s1_shift_q  <= '0;
      s1_relu_q   <= 1'b0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      grp_open_q  <= grp_open_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      grp_shift_q <= grp_shift_d;
      grp_relu_q  <= grp_relu_d;
      s1_shift_q  <= s1_shift_d;
      s1_relu_q   <= s1_relu_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  // Open group in stage 1, or its last beat still waiting for stage 2.
  assign busy      = grp_open_q | s1_valid;

endmodule
